// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add multiplier retiring one multiplier bit per clock, valid/ready on both sides.
// Define MUL_SIGNED_EN to treat operands and product as two's complement.
module seq_multiplier #(
  parameter int M_WID = 32,
  parameter int Q_WID = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [M_WID-1:0]       m_in,
  input  logic [Q_WID-1:0]       q_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [M_WID+Q_WID-1:0] product,
  output logic                   busy
);

  localparam int CW = $clog2(Q_WID + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(Q_WID - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [M_WID:0]           a_q, a_d;
  logic [Q_WID-1:0]         q_q, q_d;
  logic [M_WID-1:0]         m_q, m_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [M_WID+Q_WID-1:0]   prod_q, prod_d;

  logic [M_WID:0]           m_ext;
  logic [M_WID:0]           sum;
  logic [M_WID:0]           a_shift;
  logic [Q_WID-1:0]         q_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  // In signed mode the last multiplier bit carries negative weight, hence the subtract.
  always_comb begin
`ifdef MUL_SIGNED_EN
    m_ext = {m_q[M_WID-1], m_q};
    if (q_q[0] && (cnt_q == LAST_ITER)) begin
      sum = a_q - m_ext;
    end else if (q_q[0]) begin
      sum = a_q + m_ext;
    end else begin
      sum = a_q;
    end
    a_shift = {sum[M_WID], sum[M_WID:1]};
`else
    m_ext = {1'b0, m_q};
    sum   = q_q[0] ? (a_q + m_ext) : a_q;
    a_shift = {1'b0, sum[M_WID:1]};
`endif
    q_shift = {sum[0], q_q[Q_WID-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          m_d     = m_in;
          q_d     = q_in;
          a_d     = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy  = 1'b1;
        a_d   = a_shift;
        q_d   = q_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          prod_d  = {a_shift[M_WID-1:0], q_shift};
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign product = prod_q;

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-and-add multiplier, the multi-cycle successor to the team's combinational carry-lookahead array multiplier. It trades area for latency: one adder of width M_WID+1 processes one multiplier bit per clock. Operands are accepted and results returned over valid/ready handshakes, so the block sits directly in a streaming datapath. An optional compile-time two's-complement mode is provided.

## Interface
- M_WID, 32, multiplicand width (≥2)
- Q_WID, 32, multiplier width and iteration count (≥2)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept operands; high only in IDLE
- m_in  input  M_WID  multiplicand
- q_in  input  Q_WID  multiplier
- out_valid  output  1  product valid; high only in DONE
- out_ready  input  1  consumer accepts product
- product  output  M_WID+Q_WID  result, held stable while out_valid
- busy  output  1  high in BUSY state

## Operation
- States: IDLE, BUSY, DONE. Transitions: IDLE→BUSY on in_valid&&in_ready; BUSY→DONE when iteration count reaches Q_WID; DONE→IDLE on out_ready. No other transitions.
- Accept: capture m_in into M register; q_in into Q register (low half of shift pair); clear A register (M_WID+1 bits) and counter (clog2(Q_WID+1) bits).
- Each BUSY cycle: if Q[0], sum = A + {0,M}, else sum = A; {A,Q} ← {sum,Q} >> 1 (logical, unsigned mode); counter increments.
- After Q_WID iterations, product = {A[M_WID-1:0], Q}. The A carry bit is always 0 at completion in unsigned mode.
- product register updates only on the BUSY→DONE edge and holds through DONE and IDLE until the next completion.
- in_valid outside IDLE is ignored; operand inputs may change freely after acceptance.
- in_ready and out_valid are never high in the same cycle; no accept/drain overlap.

## Timing
- Reset (async assert, synchronous-release assumed from the system): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, A/Q/M/counter=0.
- Accept on edge 0; iterations on edges 1..Q_WID; out_valid rises after edge Q_WID. Latency is Q_WID cycles from the accept edge to out_valid.
- Minimum initiation interval is Q_WID+2 cycles with out_ready tied high (accept, Q_WID iterations, drain edge, return to IDLE).
- Backpressure: out_valid and product hold indefinitely while out_ready=0.
- out_ready sampled while not in DONE has no effect.
- rst mid-BUSY or mid-DONE aborts the operation immediately. No product is emitted and the state is IDLE on the first edge after release.

## Configuration
- MUL_SIGNED_EN defined: operands and product are two's complement.
  - A is sign-extended: sum = A + {M[MSB],M}.
  - Shift is arithmetic on A.
  - On the final iteration (counter==Q_WID-1), if Q[0] then sum = A − {M[MSB],M}, providing the multiplier sign-bit weight.
  - Latency is unchanged.
- MUL_SIGNED_EN undefined: unsigned behaviour as in Operation; no subtractor logic is synthesised.

## Test plan
- M_WID=Q_WID=8, unsigned, out_ready=1: 13×11 → out_valid 8 cycles after accept, product=0x008F; 255×255 → 0xFE01.
- Zero operands: 0×0xAB → 0x0000; 0xAB×0 → 0x0000. Each completes in exactly 8 cycles.
- Backpressure: 200×3, out_ready held low 5 cycles after out_valid → product=0x0258 stable, in_ready=0 throughout; drain, then in_ready=1 on the following cycle.
- Reset mid-op: assert rst at iteration 4 of 100×100 → out_valid never rises, all outputs return to reset values; next op 7×6 → 0x002A.
- Asymmetric M_WID=16, Q_WID=4: 0xFFFF×0xF → 0xEFFF1, latency 4; in_valid pulses during BUSY are ignored.
- MUL_SIGNED_EN, 8×8: −3×5 → 0xFFF1; −128×−128 → 0x4000; 127×−1 → 0xFF81.
